adder_burst_accumulator: RTL and testbench
==========================================

// Module: adder_burst_accumulator
// PURPOSE
//   Burst accumulator that consumes the 32-bit adder: sums (or subtracts) a stream of LEN signed operands
//   into a running register using one CarryBypassAdder (N=32) instance as its only add datapath.
//   Sits downstream of the adder (registers Sum/Cout/Overflow) and upstream of result consumers.
//   Operands arrive on a valid/ready stream.
//   The result is held on a valid/ready output until it is taken.
// PARAMETERS
//   LEN_W     8   width of burst-length input; max burst = 2**LEN_W-1 operands
//   SATURATE  0   1: clamp accumulator on signed overflow; 0: wrap (two's complement)
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   rst           in   1      synchronous reset, active-high
//   start         in   1      begin burst; sampled only in IDLE
//   len           in   LEN_W  operand count for burst, sampled with start
//   sub           in   1      0: acc += data, 1: acc -= data; sampled with start
//   in_valid      in   1      in_data valid
//   in_ready      out  1      block accepts in_data this cycle
//   in_data       in   32     signed operand
//   out_valid     out  1      result valid
//   out_ready     in   1      consumer takes result
//   out_sum       out  32     signed accumulated result
//   out_cout      out  1      carry-out of last accepted addition
//   out_overflow  out  1      sticky: any step of burst overflowed (signed)
//   busy          out  1      high in ACCUM and DONE
// BEHAVIOUR
//   Reset
//   - rst=1 at an edge: state<=IDLE; acc, count, out_cout, out_overflow, mode <= 0.
//     Outputs in_ready=0, out_valid=0, busy=0, out_sum=0.
//   - Reset mid-burst aborts with no output; pending operands are dropped.
//   FSM states and transitions
//   - IDLE->ACCUM on start & len!=0. Load acc=0, count=len, mode=sub; clear sticky overflow and out_cout.
//   - IDLE->DONE on start & len==0. out_sum=0, out_cout=0, out_overflow=0; out_valid the next cycle.
//   - ACCUM:
//     - in_ready=1.
//     - On in_valid&in_ready, the adder sees A=acc, B=in_data^{32{mode}}, Cin=mode.
//     - Then acc<=Sum, out_cout<=Cout, out_overflow<=out_overflow|Overflow, count<=count-1.
//     - If count==1 at accept -> DONE.
//   - DONE: out_valid=1, in_ready=0. out_sum/out_cout/out_overflow stable until out_ready=1, then -> IDLE.
//   - start is ignored outside IDLE, including the DONE cycle where out_ready=1. A new burst needs one IDLE cycle.
//   Datapath and timing
//   - One operand per cycle max; in_valid gaps stall with no state change.
//   - Latency: out_valid asserts the cycle after the last operand is accepted.
//   - Throughput is LEN+2 cycles per burst at full rate.
//   - out_sum == acc register (registered, no combinational path from in_data).
//   - SATURATE=1 and Overflow on a step: acc<=acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF.
//     Overflow sign is taken from A=acc; the sticky flag is still set.
//   - Arithmetic is modulo 2**32 when SATURATE=0; out_cout is raw adder carry (borrow-inverted in sub mode).
//   - len, sub, in_data changes while not sampled have no effect.
// TESTING
//   1. len=4, sub=0, data 1,2,3,4 back-to-back -> out_sum=10, ovf=0, out_valid 1 cycle after 4th accept.
//   2. len=2, sub=0, data 7FFF_FFFF,1: SATURATE=0 -> out_sum=8000_0000, ovf=1; SATURATE=1 -> out_sum=7FFF_FFFF, ovf=1.
//   3. len=2, sub=1, data 5,7 -> out_sum=FFFF_FFF4 (-12), out_cout=1, ovf=0.
//   4. start with len=0 -> out_valid next cycle, out_sum=0; out_ready held low 5 cycles -> outputs stable, then IDLE.
//   5. len=3, in_valid toggling 1,0,1,0,1 plus start pulses during ACCUM/DONE -> gaps stall, starts ignored, sum correct.
//   6. rst asserted after 2 of 4 operands -> all outputs 0 next cycle; new burst len=1 data -3 -> out_sum=FFFF_FFFD.

Source files
------------

// File: rtl/adder_burst_accumulator.sv
// Burst accumulator: adds or subtracts a stream of signed 32-bit operands into a running
// register through a single carry-bypass adder, then holds the result until it is taken.
module adder_burst_accumulator #(
    parameter int unsigned LEN_W    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             busy
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [DW-1:0]    add_b, add_sum;
    logic             add_cout, add_ovf;

    // Subtraction is acc + ~data + 1, so the mode bit doubles as carry-in.
    assign add_b = in_data ^ {DW{mode_q}};

    CarryBypassAdder #(.N(DW)) u_add (
        .A        (acc_q),
        .B        (add_b),
        .Cin      (mode_q),
        .Sum      (add_sum),
        .Cout     (add_cout),
        .Overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = len;
                    mode_d  = sub;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    // Saturation direction follows the sign of the running value.
                    if (SATURATE && add_ovf) begin
                        acc_d = acc_q[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                    end else begin
                        acc_d = add_sum;
                    end
                    cout_d  = add_cout;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = acc_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;
    assign busy         = busy_q;

endmodule

// N-bit carry-bypass adder in 4-bit blocks; a fully propagating block forwards its carry-in.
module CarryBypassAdder #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Overflow
);
    localparam int unsigned BLK = 4;
    localparam int unsigned NB  = N / BLK;

    logic c, rc, bp, p;

    always_comb begin
        Sum = '0;
        c   = Cin;
        rc  = 1'b0;
        bp  = 1'b0;
        p   = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            rc = c;
            bp = 1'b1;
            for (int i = 0; i < int'(BLK); i++) begin
                p              = A[b*BLK+i] ^ B[b*BLK+i];
                Sum[b*BLK+i]   = p ^ rc;
                rc             = (A[b*BLK+i] & B[b*BLK+i]) | (p & rc);
                bp             = bp & p;
            end
            c = bp ? c : rc;
        end
        Cout     = c;
        Overflow = (A[N-1] == B[N-1]) && (Sum[N-1] != A[N-1]);
    end

endmodule

// File: tb/tb_adder_burst_accumulator.sv
// Bench for adder_burst_accumulator: wrap and saturating instances share stimulus and are
// checked against an arithmetic reference through per-instance scoreboards.
module tb_adder_burst_accumulator;
    logic        clk, rst, start, sub, in_valid, out_ready;
    logic [7:0]  len;
    logic [31:0] in_data;

    logic        in_ready0, out_valid0, out_cout0, out_ovf0, busy0;
    logic        in_ready1, out_valid1, out_cout1, out_ovf1, busy1;
    logic [31:0] out_sum0, out_sum1;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        snap0, snap1;
    bit          held0, held1;
    logic [31:0] bd[$];
    int          total, bad;

    adder_burst_accumulator #(.LEN_W(8), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_cout(out_cout0), .out_overflow(out_ovf0), .busy(busy0)
    );

    adder_burst_accumulator #(.LEN_W(8), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_cout(out_cout1), .out_overflow(out_ovf1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step: exact signed arithmetic, then wrap or clamp.
    function automatic void step(input logic [31:0] acc, input logic [31:0] d, input logic s,
                                 input bit sat, output logic [31:0] nacc, output logic co,
                                 output logic ov);
        longint      r;
        logic [63:0] rv;
        logic [32:0] t;
        if (s) r = longint'($signed(acc)) - longint'($signed(d));
        else   r = longint'($signed(acc)) + longint'($signed(d));
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        t  = {1'b0, acc} + {1'b0, (s ? ~d : d)} + 33'(s);
        co = t[32];
        rv = 64'(r);
        if (sat && ov) nacc = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else           nacc = rv[31:0];
    endfunction

    task automatic mon_one(input int k, input logic v, input logic [31:0] s, input logic c,
                           input logic o);
        exp_t e;
        bit   h;
        h = (k == 0) ? held0 : held1;
        if (!v) begin
            h = 1'b0;
        end else if (!h) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_result dut=%0d act=%0h req=none", k, s);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sum%0d", k), s, e.sum);
                chk($sformatf("cout%0d", k), 32'(c), 32'(e.cout));
                chk($sformatf("ovf%0d", k), 32'(o), 32'(e.ovf));
                if (k == 0) snap0 = e; else snap1 = e;
            end
            h = 1'b1;
        end else begin
            e = (k == 0) ? snap0 : snap1;
            chk($sformatf("hold%0d", k), {s[29:0], c, o}, {e.sum[29:0], e.cout, e.ovf});
        end
        if (v && out_ready) h = 1'b0;
        if (k == 0) held0 = h; else held1 = h;
    endtask

    always @(negedge clk) begin
        mon_one(0, out_valid0, out_sum0, out_cout0, out_ovf0);
        mon_one(1, out_valid1, out_sum1, out_cout1, out_ovf1);
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_sum0"}, out_sum0, 32'h0);
        chk({nm, "_sum1"}, out_sum1, 32'h0);
        chk({nm, "_flags"}, {26'h0, out_valid0, out_valid1, in_ready0, in_ready1, busy0, busy1},
            32'h0);
        chk({nm, "_co"}, {28'h0, out_cout0, out_cout1, out_ovf0, out_ovf1}, 32'h0);
    endtask

    // One burst from bd[]; gaps and stray starts by percentage, result held `hold` cycles.
    task automatic run_burst(input int n, input logic s, input int gap_pct, input int hold,
                             input bit noise);
        logic [31:0] a0, a1;
        logic        c0, c1, o0, o1, sc, so;
        exp_t        e;
        a0 = '0; a1 = '0; c0 = 1'b0; c1 = 1'b0; o0 = 1'b0; o1 = 1'b0;
        start = 1'b1; len = 8'(n); sub = s;
        tick();
        start = 1'b0; len = 8'($urandom); sub = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                start    = noise;
                tick();
                start    = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = bd[i];
            chk("in_ready", 32'(in_ready0 & in_ready1), 32'h1);
            chk("busy_accum", 32'(busy0 & busy1), 32'h1);
            step(a0, bd[i], s, 1'b0, a0, sc, so); c0 = sc; o0 = o0 | so;
            step(a1, bd[i], s, 1'b1, a1, sc, so); c1 = sc; o1 = o1 | so;
            tick();
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        e.sum = a0; e.cout = c0; e.ovf = o0; q0.push_back(e);
        e.sum = a1; e.cout = c1; e.ovf = o1; q1.push_back(e);
        chk("latency_valid", 32'(out_valid0 & out_valid1), 32'h1);
        chk("done_in_ready", 32'(in_ready0 | in_ready1), 32'h0);
        for (int h = 0; h < hold; h++) begin
            start = noise;
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start     = noise;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_valid", 32'(out_valid0 | out_valid1), 32'h0);
        chk("idle_busy", 32'(busy0 | busy1), 32'h0);
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        total = 0; bad = 0; held0 = 1'b0; held1 = 1'b0;
        rst = 1'b1; start = 1'b0; len = '0; sub = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        bd = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_burst(4, 1'b0, 0, 0, 1'b0);
        bd = '{32'h7FFF_FFFF, 32'h1};
        run_burst(2, 1'b0, 0, 1, 1'b0);
        bd = '{32'd5, 32'd7};
        run_burst(2, 1'b1, 0, 0, 1'b0);
        bd = '{};
        run_burst(0, 1'b0, 0, 5, 1'b0);
        bd = '{32'd10, 32'd20, 32'd30};
        run_burst(3, 1'b0, 50, 3, 1'b1);

        // Abort mid-burst, then a fresh single-operand burst.
        start = 1'b1; len = 8'd4; sub = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 100);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("mid_reset");
        bd = '{32'hFFFF_FFFD};
        run_burst(1, 1'b0, 0, 0, 1'b0);

        for (int b = 0; b < 40; b++) begin
            n = (b == 20) ? 255 : int'($urandom_range(12));
            bd = '{};
            for (int i = 0; i < n; i++) bd.push_back(rnd_data());
            run_burst(n, 1'($urandom), int'($urandom_range(40)), int'($urandom_range(3)),
                      1'($urandom));
            if ($urandom_range(3) == 0) tick();
        end

        tick();
        tick();
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
